// File: rtl/turn_arbiter.sv
// Turn arbiter for an N-player Connect Four datapath: validates drops, tracks
// per-column fill, rotates turns, and handles timeout, lock, draw and restart.

module turn_arbiter_col #(
    parameter int NUM_ROWS = 6,
    parameter int ROW_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] fill,
    output logic             full
);
    logic [ROW_W-1:0] fill_q, fill_d;

    always_comb begin
        fill_d = fill_q;
        if (clr)
            fill_d = '0;
        else if (inc)
            fill_d = fill_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fill_q <= '0;
        else        fill_q <= fill_d;
    end

    assign fill = fill_q;
    assign full = (fill_q == ROW_W'(NUM_ROWS));
endmodule

module turn_arbiter #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_COLS     = 8,
    parameter int NUM_ROWS     = 6,
    parameter int TURN_TIMEOUT = 0,
    localparam int COL_W = $clog2(NUM_COLS + 1),
    localparam int ROW_W = $clog2(NUM_ROWS + 1),
    localparam int PW    = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int TW    = ($clog2(TURN_TIMEOUT + 1) > 1) ? $clog2(TURN_TIMEOUT + 1) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                move_valid,
    input  logic [COL_W-1:0]    column,
    input  logic                game_over,
    input  logic                new_game,
    output logic [PW-1:0]       player,
    output logic                accept,
    output logic                reject,
    output logic [1:0]          reject_code,
    output logic [COL_W-1:0]    drop_col,
    output logic [ROW_W-1:0]    drop_row,
    output logic [PW-1:0]       drop_player,
    output logic                timeout,
    output logic [NUM_COLS-1:0] col_full,
    output logic                board_full
);
    typedef enum logic [1:0] {ST_PLAY, ST_LOCK, ST_DRAW} state_e;

    localparam logic [TW-1:0] TMAX = TW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

    state_e                         state_q, state_d;
    logic [PW-1:0]                  player_q, player_d, player_nxt;
    logic [TW-1:0]                  timer_q, timer_d;
    logic                           accept_q, accept_d, reject_q, reject_d;
    logic                           timeout_q, timeout_d;
    logic [1:0]                     code_q, code_d;
    logic [COL_W-1:0]               dcol_q, dcol_d;
    logic [ROW_W-1:0]               drow_q, drow_d;
    logic [PW-1:0]                  dpl_q, dpl_d;

    logic [NUM_COLS-1:0][ROW_W-1:0] fill;
    logic [NUM_COLS-1:0]            full, col_hit, near_full;
    logic [ROW_W-1:0]               sel_fill;
    logic                           sel_full, col_ok, fills_last, locked;

    for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
        turn_arbiter_col #(.NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W)) u_col (
            .clk   (clk),
            .reset (reset),
            .clr   (new_game),
            .inc   (accept_d & col_hit[i]),
            .fill  (fill[i]),
            .full  (full[i])
        );
    end

    always_comb begin
        sel_fill  = '0;
        sel_full  = 1'b0;
        col_hit   = '0;
        near_full = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            near_full[i] = (fill[i] == ROW_W'(NUM_ROWS - 1));
            if (column == COL_W'(i + 1)) begin
                col_hit[i] = 1'b1;
                sel_fill   = fill[i];
                sel_full   = full[i];
            end
        end
        col_ok     = (column != '0) && (column <= COL_W'(NUM_COLS));
        // An accept here fills the board if every other column is already full.
        fills_last = &(full | (col_hit & near_full));
        locked     = (state_q != ST_PLAY) || game_over;
        player_nxt = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        timer_d   = timer_q;
        accept_d  = 1'b0;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
        code_d    = 2'd0;
        dcol_d    = dcol_q;
        drow_d    = drow_q;
        dpl_d     = dpl_q;
        if (new_game) begin
            state_d  = ST_PLAY;
            player_d = '0;
            timer_d  = '0;
            dcol_d   = '0;
            drow_d   = '0;
            dpl_d    = '0;
        end else begin
            if (move_valid) begin
                if (locked) begin
                    reject_d = 1'b1;
                    code_d   = 2'd3;
                end else if (!col_ok) begin
                    reject_d = 1'b1;
                    code_d   = 2'd1;
                end else if (sel_full) begin
                    reject_d = 1'b1;
                    code_d   = 2'd2;
                end else begin
                    accept_d = 1'b1;
                    dcol_d   = column;
                    drow_d   = sel_fill;
                    dpl_d    = player_q;
                end
            end
            timeout_d = (TURN_TIMEOUT > 0) && (state_q == ST_PLAY) && !accept_d && (timer_q == TMAX);
            if (accept_d || timeout_d)
                player_d = player_nxt;
            if ((TURN_TIMEOUT == 0) || (state_q != ST_PLAY) || accept_d || timeout_d)
                timer_d = '0;
            else
                timer_d = timer_q + 1'b1;
            case (state_q)
                ST_PLAY: if (game_over)                 state_d = ST_LOCK;
                         else if (accept_d && fills_last) state_d = ST_DRAW;
                ST_LOCK: if (!game_over)                state_d = ST_PLAY;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PLAY;
            player_q  <= '0;
            timer_q   <= '0;
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
            code_q    <= 2'd0;
            dcol_q    <= '0;
            drow_q    <= '0;
            dpl_q     <= '0;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            timer_q   <= timer_d;
            accept_q  <= accept_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
            code_q    <= code_d;
            dcol_q    <= dcol_d;
            drow_q    <= drow_d;
            dpl_q     <= dpl_d;
        end
    end

    assign player      = player_q;
    assign accept      = accept_q;
    assign reject      = reject_q;
    assign reject_code = code_q;
    assign drop_col    = dcol_q;
    assign drop_row    = drow_q;
    assign drop_player = dpl_q;
    assign timeout     = timeout_q;
    assign col_full    = full;
    assign board_full  = (state_q == ST_DRAW);
endmodule

// File: doc/turn_arbiter.md
Name: turn_arbiter

Overview:
- Parametrised successor to the two-player turn tracker for the Connect Four datapath.
- Supports N players and configurable board dimensions, and owns the per-column fill counters internally.
- Validates each drop request and reports the landing row, with accept/reject reason.
- Adds an optional per-turn timeout, game-over lock, draw (board-full) detection and a new-game restart. Sits between the column-select input logic and the board RAM / win checker.

Parameters:
- NUM_PLAYERS, 2, number of players in rotation (2..8)
- NUM_COLS, 8, board columns (2..15)
- NUM_ROWS, 6, board rows (2..15)
- TURN_TIMEOUT, 0, cycles a player may idle before the turn is forfeited; 0 disables the timeout
- Derived: COL_W = $clog2(NUM_COLS+1); ROW_W = $clog2(NUM_ROWS+1); PW = max(1, $clog2(NUM_PLAYERS)); TW = max(1, $clog2(TURN_TIMEOUT+1))

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- move_valid  in  1  one-cycle request to drop a token
- column  in  COL_W  1-based column of request; 0 = no column
- game_over  in  1  level from win checker; locks play while high
- new_game  in  1  one-cycle synchronous restart
- player  out  PW  index of player whose turn it is
- accept  out  1  registered pulse: last request placed
- reject  out  1  registered pulse: last request refused
- reject_code  out  2  reason: 0 none, 1 bad column, 2 column full, 3 locked
- drop_col  out  COL_W  column of last accepted drop, held until next accept
- drop_row  out  ROW_W  0-based row of last accepted drop (0 = bottom), held until next accept
- drop_player  out  PW  player who made last accepted drop
- timeout  out  1  registered pulse: turn forfeited by timer
- col_full  out  NUM_COLS  bit i set when column i+1 holds NUM_ROWS tokens
- board_full  out  1  high in DRAW state

Behaviour:
- Reset (reset==0, async):
  - fill counters = 0; player = 0; state = PLAY; timer = 0.
  - All pulses = 0; reject_code = 0; drop_col, drop_row, drop_player = 0; col_full = 0; board_full = 0.
- FSM states:
  - PLAY: normal operation.
  - LOCK: entered while game_over=1 in PLAY; returns to PLAY when game_over drops.
  - DRAW: entered on the cycle after the accept that fills the last free cell; sticky until new_game or reset.
- Request evaluation (move_valid=1 sampled at edge k; outputs valid after edge k, one cycle latency; accept, reject and timeout are single-cycle pulses):
  - Priority 1: state LOCK/DRAW, or game_over=1 -> reject, code 3.
  - Priority 2: column==0 or column>NUM_COLS -> reject, code 1.
  - Priority 3: fill[column-1]==NUM_ROWS -> reject, code 2.
  - Otherwise accept: drop_row = old fill; fill increments; drop_col = column; drop_player = player; player advances.
  - Rejects never change player, counters or timer.
- Player advance: player+1, wrapping NUM_PLAYERS-1 -> 0.
- Timer (TURN_TIMEOUT>0, state PLAY only):
  - Increments each cycle; clears on accept, timeout, new_game, and on any cycle not in PLAY.
  - When timer==TURN_TIMEOUT-1 and no accept that cycle: player advances, timeout pulses, timer clears.
  - An accept on the same cycle takes precedence; timeout stays 0.
- new_game:
  - Clears counters, player, timer and drop outputs; state -> PLAY.
  - Takes precedence over a simultaneous move_valid: no accept/reject for that request.
  - If game_over is still high, the next cycle enters LOCK.
- col_full and board_full are registered, reflecting counters after the same edge.
- Async reset mid-game returns all state immediately, independent of clk.

Test Plan:
- NUM_PLAYERS=3: accepted drops to columns 1,2,3,1 -> player sequence 0->1->2->0->1; drop_row for the second column-1 drop = 1.
- Fill column 2 with 6 drops, then request column 2 -> reject, code 2, col_full[1]=1, player unchanged; next request to column 3 accepted.
- column=0 and column=9 with move_valid (NUM_COLS=8) -> reject, code 1 each; no counter change.
- TURN_TIMEOUT=4, no requests -> timeout pulse every 4 cycles, player advances each time. Accept issued on the 4th cycle -> accept only, no timeout.
- NUM_COLS=2, NUM_ROWS=2: 4 accepted drops -> board_full=1 in DRAW; further request -> reject, code 3. new_game -> board_full=0, player=0, col_full=0.
- game_over=1 -> request rejected, code 3. Assert reset low between clock edges mid-game -> outputs cleared before the next edge.
